// File: rtl/belief_update.sv
// belief_update: Bayes belief update for a 2-state / 3-action / 2-observation
// POMDP. Prediction and correction are done in unsigned Q0.WIDTH, then the
// posterior is normalised with a serial restoring divider (one bit per cycle).
module belief_update #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_belief,
  input  logic [1:0]       action,
  input  logic             observation,
  input  logic [WIDTH-1:0] trans   [0:2][0:1][0:1],
  input  logic [WIDTH-1:0] observe [0:2][0:1][0:1],
  output logic [WIDTH-1:0] belief  [0:1],
  output logic             belief_valid,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, PRED0, PRED1, CORR, DIV} state_t;

  state_t state, state_nx;

  logic [1:0]       act_q;
  logic             obs_q;
  logic [WIDTH-1:0] p0_q, p1_q;
  logic [WIDTH-1:0] u1_q;
  logic [WIDTH:0]   n_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [CW-1:0]    cnt_q;

  logic             sp_sel;
  logic [WIDTH-1:0] p_c, u0_c, u1_c;
  logic [WIDTH:0]   n_c;
  logic [WIDTH+1:0] trial;
  logic             q_bit;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] q_nx, fin_q;

  // Full-width unsigned product of two Q0.WIDTH values.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  endfunction

  // Drop the fraction bits of a sum of two products, clamping to all-ones.
  function automatic logic [WIDTH-1:0] sat_hi(input logic [2*WIDTH:0] s);
    logic [WIDTH:0] hi;
    hi = (WIDTH+1)'(s >> WIDTH);
    return hi[WIDTH] ? ONES : hi[WIDTH-1:0];
  endfunction

  // Prediction for the successor state selected by the current PRED step,
  // correction of both predictions, and one restoring-division step.
  always_comb begin
    sp_sel = (state == PRED1);
    p_c    = sat_hi({1'b0, mul_full(trans[act_q][0][sp_sel], belief[0])} +
                    {1'b0, mul_full(trans[act_q][1][sp_sel], belief[1])});
    u0_c   = WIDTH'(mul_full(observe[act_q][0][obs_q], p0_q) >> WIDTH);
    u1_c   = WIDTH'(mul_full(observe[act_q][1][obs_q], p1_q) >> WIDTH);
    n_c    = {1'b0, u0_c} + {1'b0, u1_c};
    trial  = {rem_q, 1'b0};
    q_bit  = (trial >= {1'b0, n_q});
    rem_nx = q_bit ? (WIDTH+1)'(trial - {1'b0, n_q}) : (WIDTH+1)'(trial);
    q_nx   = WIDTH'({quot_q, q_bit});
    // u1 == 0 means the exact quotient is 1.0, which does not fit in Q0.WIDTH.
    fin_q  = (u1_q == '0) ? ONES : q_nx;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: fixed 3-cycle front end followed by WIDTH divide steps.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en_belief && action != 2'd3) state_nx = PRED0;
      PRED0:   state_nx = PRED1;
      PRED1:   state_nx = CORR;
      CORR:    state_nx = (n_c == '0) ? IDLE : DIV;
      DIV:     if (cnt_q == LAST_BIT) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath registers, belief storage and the registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q        <= '0;
      obs_q        <= 1'b0;
      p0_q         <= '0;
      p1_q         <= '0;
      u1_q         <= '0;
      n_q          <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      cnt_q        <= '0;
      belief[0]    <= {1'b1, {(WIDTH-1){1'b0}}};
      belief[1]    <= {1'b0, {(WIDTH-1){1'b1}}};
      belief_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      belief_valid <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE: begin
          if (en_belief) begin
            if (action == 2'd3) begin
              err <= 1'b1;
            end else begin
              act_q <= action;
              obs_q <= observation;
            end
          end
        end
        PRED0: p0_q <= p_c;
        PRED1: p1_q <= p_c;
        CORR: begin
          u1_q   <= u1_c;
          n_q    <= n_c;
          rem_q  <= {1'b0, u0_c};
          quot_q <= '0;
          cnt_q  <= '0;
          if (n_c == '0) err <= 1'b1;
        end
        DIV: begin
          rem_q  <= rem_nx;
          quot_q <= q_nx;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            belief[0]    <= fin_q;
            belief[1]    <= ONES - fin_q;
            belief_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
